// File: rtl/rx_frame_if.sv
// Serial byte link into rx_frame plus its status and storage read port (master = transmitter/reader side).
interface rx_frame_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              tx_data;
  logic              tx_vld;
  logic              tx_finish;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_byte;
  logic              rx_byte_vld;
  logic [ADDR_W:0]   rx_count;
  logic              rx_done;
  logic              rx_err;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output tx_data, tx_vld, tx_finish, rd_addr,
    input  rx_ready, rx_byte, rx_byte_vld, rx_count, rx_done, rx_err, rd_data
  );

  modport slave (
    input  tx_data, tx_vld, tx_finish, rd_addr,
    output rx_ready, rx_byte, rx_byte_vld, rx_count, rx_done, rx_err, rd_data
  );
endinterface

// File: rtl/rx_frame.sv
// Serial LSB-first byte receiver filling a DEPTH-entry frame store; byte pulse 1 cycle after last bit, rd_data 1 cycle.
// No backpressure: rx_ready only in READY. Define RX_FRAME_CHK_EN to turn tx_vld gaps / early finish into a sticky rx_err.
module rx_frame #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input logic       clk,
  input logic       clr,
  rx_frame_if.slave bus
);
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {IDLE, READY, RECV, STORE, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] byte_q;
  logic              byte_vld_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef RX_FRAME_CHK_EN
  logic              err_q, err_set;
`endif

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
`ifdef RX_FRAME_CHK_EN
    err_set     = 1'b0;
`endif
    case (state)
      IDLE:  state_nxt = READY;
      READY: begin
        // finish wins over a simultaneous valid bit
        if (bus.tx_finish) begin
          state_nxt = DONE;
        end else if (bus.tx_vld) begin
          shreg_nxt[0] = bus.tx_data;
          bit_cnt_nxt  = BIT_W'(1);
          state_nxt    = (DATA_W == 1) ? STORE : RECV;
        end
      end
      RECV: begin
        if (bus.tx_finish) begin
          state_nxt = DONE;
`ifdef RX_FRAME_CHK_EN
          err_set   = 1'b1;
`endif
        end else if (bus.tx_vld) begin
          shreg_nxt[bit_cnt] = bus.tx_data;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            bit_cnt_nxt = '0;
            state_nxt   = STORE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
`ifdef RX_FRAME_CHK_EN
        else begin
          err_set   = 1'b1;
          state_nxt = DONE;
        end
`endif
      end
      // count_q still holds the pre-store value here
      STORE:   state_nxt = (count_q == (ADDR_W+1)'(DEPTH - 1)) ? DONE : READY;
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
      count_q    <= '0;
      wr_addr    <= '0;
      rd_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_vld_q <= (state_nxt == STORE);
      if (state_nxt == STORE) byte_q <= shreg_nxt;
      if (state == STORE) begin
        mem[wr_addr] <= byte_q;
        wr_addr      <= wr_addr + 1'b1;
        count_q      <= count_q + 1'b1;
      end
      rd_q <= mem[bus.rd_addr];
    end
  end

`ifdef RX_FRAME_CHK_EN
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end
  assign bus.rx_err = err_q;
`else
  assign bus.rx_err = 1'b0;
`endif

  assign bus.rx_ready    = (state == READY);
  assign bus.rx_done     = (state == DONE);
  assign bus.rx_byte     = byte_q;
  assign bus.rx_byte_vld = byte_vld_q;
  assign bus.rx_count    = count_q;
  assign bus.rd_data     = rd_q;
endmodule

// File: tb/tb_rx_frame.sv
// Randomised frame bench for rx_frame against a byte-list reference model.
module tb_rx_frame;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  rx_frame_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  rx_frame #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .clr(clr), .bus(bus.slave));

  int tests = 0;
  int fails = 0;

  // reference model: bytes accepted so far, in arrival order
  logic [7:0] exp_mem [DEPTH];
  int         exp_count;
`ifdef RX_FRAME_CHK_EN
  localparam logic ERR_ON_ABORT = 1'b1;
`else
  localparam logic ERR_ON_ABORT = 1'b0;
`endif

  function automatic void model_clear();
    exp_count = 0;
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h00;
  endfunction

  function automatic void model_accept(input logic [7:0] b);
    if (exp_count < DEPTH) begin
      exp_mem[exp_count] = b;
      exp_count++;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    bus.tx_vld = 1'b0;
    bus.tx_finish = 1'b0;
    model_clear();
    @(negedge clk);
    clr = 1'b1;
  endtask

  // called at a negedge; gives up after 4 edges
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_after, input int gap_len,
                           output logic vld_seen, output logic [7:0] byte_seen);
    for (int i = 0; i < 8; i++) begin
      bus.tx_vld  = 1'b1;
      bus.tx_data = b[i];
      @(negedge clk);
      if (i == gap_after) begin
        bus.tx_vld = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
    end
    bus.tx_vld = 1'b0;
    vld_seen  = bus.rx_byte_vld;
    byte_seen = bus.rx_byte;
    @(negedge clk);
  endtask

  task automatic send_finish(input logic with_vld);
    bus.tx_finish = 1'b1;
    bus.tx_vld    = with_vld;
    bus.tx_data   = 1'b1;
    @(negedge clk);
    bus.tx_finish = 1'b0;
    bus.tx_vld    = 1'b0;
  endtask

  task automatic read_mem(input int a, output logic [7:0] d);
    bus.rd_addr = a[1:0];
    @(negedge clk);
    d = bus.rd_data;
  endtask

  task automatic test_reset();
    bit ok;
    @(negedge clk);
    tests++;
    if ({bus.rx_ready, bus.rx_byte_vld, bus.rx_done, bus.rx_err} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {bus.rx_ready, bus.rx_byte_vld, bus.rx_done, bus.rx_err});
    end
    tests++;
    if ({bus.rx_byte, bus.rd_data, bus.rx_count} !== 19'h0) begin
      fails++; $display("FAIL reset_data: byte %h rd %h count %0d want 0", bus.rx_byte, bus.rd_data, bus.rx_count);
    end
    clr = 1'b1;
    tests++;
    if (bus.rx_ready !== 1'b0) begin
      fails++; $display("FAIL reset_idle_ready: got %b want 0", bus.rx_ready);
    end
    wait_ready(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL reset_ready_rise: rx_ready not seen within bound");
    end
  endtask

  task automatic test_full_frame();
    logic [7:0] pat [4];
    logic       v;
    logic [7:0] b, d;
    bit         ok;
    pat[0] = 8'hA5; pat[1] = 8'h3C; pat[2] = 8'hFF; pat[3] = 8'h01;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_ready(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL full_ready[%0d]: timeout", k); end
      send_byte(pat[k], -1, 0, v, b);
      model_accept(pat[k]);
      tests++;
      if (v !== 1'b1 || b !== pat[k]) begin
        fails++; $display("FAIL full_byte[%0d]: vld %b byte %h want 1 %h", k, v, b, pat[k]);
      end
    end
    tests++;
    if (bus.rx_count !== 3'(exp_count) || bus.rx_done !== 1'b1 || bus.rx_ready !== 1'b0) begin
      fails++; $display("FAIL full_status: count %0d done %b ready %b want %0d 1 0", bus.rx_count, bus.rx_done, bus.rx_ready, exp_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      read_mem(a, d);
      tests++;
      if (d !== exp_mem[a]) begin fails++; $display("FAIL full_mem[%0d]: got %h want %h", a, d, exp_mem[a]); end
    end
  endtask

  task automatic test_finish_early();
    logic v;
    logic [7:0] b, d;
    bit ok;
    do_reset();
    wait_ready(ok);
    send_byte(8'h12, -1, 0, v, b); model_accept(8'h12);
    tests++;
    if (v !== 1'b1 || b !== 8'h12) begin fails++; $display("FAIL early_byte0: vld %b byte %h want 1 12", v, b); end
    wait_ready(ok);
    send_byte(8'h34, -1, 0, v, b); model_accept(8'h34);
    tests++;
    if (v !== 1'b1 || b !== 8'h34) begin fails++; $display("FAIL early_byte1: vld %b byte %h want 1 34", v, b); end
    wait_ready(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL early_ready: timeout"); end
    send_finish(1'b0);
    tests++;
    if (bus.rx_count !== 3'(exp_count) || bus.rx_done !== 1'b1 || bus.rx_ready !== 1'b0) begin
      fails++; $display("FAIL early_status: count %0d done %b ready %b want %0d 1 0", bus.rx_count, bus.rx_done, bus.rx_ready, exp_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      read_mem(a, d);
      tests++;
      if (d !== exp_mem[a]) begin fails++; $display("FAIL early_mem[%0d]: got %h want %h", a, d, exp_mem[a]); end
    end
  endtask

  task automatic test_gap();
    logic v;
    logic [7:0] b;
    bit ok;
    do_reset();
    wait_ready(ok);
    send_byte(8'h5A, 3, 3, v, b);
`ifdef RX_FRAME_CHK_EN
    tests++;
    if (bus.rx_err !== 1'b1 || bus.rx_count !== 3'd0 || bus.rx_done !== 1'b1 || v !== 1'b0) begin
      fails++; $display("FAIL gap_err: err %b count %0d done %b vld %b want 1 0 1 0", bus.rx_err, bus.rx_count, bus.rx_done, v);
    end
`else
    model_accept(8'h5A);
    tests++;
    if (v !== 1'b1 || b !== 8'h5A || bus.rx_err !== 1'b0) begin
      fails++; $display("FAIL gap_byte: vld %b byte %h err %b want 1 5a 0", v, b, bus.rx_err);
    end
    tests++;
    if (bus.rx_count !== 3'(exp_count)) begin fails++; $display("FAIL gap_count: got %0d want %0d", bus.rx_count, exp_count); end
`endif
  endtask

  task automatic test_finish_with_vld();
    logic v;
    logic [7:0] b, d, r;
    bit ok;
    do_reset();
    r = 8'($urandom);
    wait_ready(ok);
    send_byte(r, -1, 0, v, b); model_accept(r);
    tests++;
    if (v !== 1'b1 || b !== r) begin fails++; $display("FAIL fv_byte: vld %b byte %h want 1 %h", v, b, r); end
    wait_ready(ok);
    send_finish(1'b1);
    repeat (3) @(negedge clk);
    tests++;
    if (bus.rx_count !== 3'(exp_count) || bus.rx_done !== 1'b1 || bus.rx_byte_vld !== 1'b0) begin
      fails++; $display("FAIL fv_status: count %0d done %b vld %b want %0d 1 0", bus.rx_count, bus.rx_done, bus.rx_byte_vld, exp_count);
    end
    read_mem(0, d);
    tests++;
    if (d !== exp_mem[0]) begin fails++; $display("FAIL fv_mem0: got %h want %h", d, exp_mem[0]); end
  endtask

  task automatic test_finish_in_recv();
    logic [7:0] r;
    bit ok;
    do_reset();
    r = 8'($urandom);
    wait_ready(ok);
    for (int i = 0; i < 3; i++) begin
      bus.tx_vld = 1'b1; bus.tx_data = r[i];
      @(negedge clk);
    end
    send_finish(1'b0);
    tests++;
    if (bus.rx_count !== 3'd0 || bus.rx_done !== 1'b1 || bus.rx_err !== ERR_ON_ABORT) begin
      fails++; $display("FAIL recv_finish: count %0d done %b err %b want 0 1 %b", bus.rx_count, bus.rx_done, bus.rx_err, ERR_ON_ABORT);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic v;
    logic [7:0] b, d;
    bit ok;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      wait_ready(ok);
      send_byte(8'h77 + 8'(k), -1, 0, v, b);
    end
    wait_ready(ok);
    for (int i = 0; i < 5; i++) begin
      bus.tx_vld = 1'b1; bus.tx_data = 1'b1;
      @(negedge clk);
    end
    clr = 1'b0;
    bus.tx_vld = 1'b0;
    model_clear();
    #1;
    tests++;
    if ({bus.rx_ready, bus.rx_byte_vld, bus.rx_done, bus.rx_err} !== 4'b0000 ||
        {bus.rx_byte, bus.rd_data, bus.rx_count} !== 19'h0) begin
      fails++; $display("FAIL midreset_outputs: ready %b byte %h count %0d rd %h want all 0", bus.rx_ready, bus.rx_byte, bus.rx_count, bus.rd_data);
    end
    @(negedge clk);
    clr = 1'b1;
    wait_ready(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL midreset_ready: timeout"); end
    send_byte(8'hC3, -1, 0, v, b); model_accept(8'hC3);
    tests++;
    if (v !== 1'b1 || b !== 8'hC3) begin fails++; $display("FAIL midreset_byte: vld %b byte %h want 1 c3", v, b); end
    wait_ready(ok);
    send_finish(1'b0);
    for (int a = 0; a < 2; a++) begin
      read_mem(a, d);
      tests++;
      if (d !== exp_mem[a]) begin fails++; $display("FAIL midreset_mem[%0d]: got %h want %h", a, d, exp_mem[a]); end
    end
  endtask

  task automatic test_after_done();
    logic v;
    logic [7:0] b, r, d;
    bit ok;
    int pulses;
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      r = 8'($urandom);
      wait_ready(ok);
      send_byte(r, -1, 0, v, b); model_accept(r);
    end
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      bus.tx_vld    = 1'($urandom);
      bus.tx_data   = 1'($urandom);
      bus.tx_finish = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (bus.rx_byte_vld === 1'b1) pulses++;
    end
    bus.tx_vld = 1'b0; bus.tx_finish = 1'b0;
    tests++;
    if (pulses !== 0 || bus.rx_count !== 3'(exp_count) || bus.rx_done !== 1'b1) begin
      fails++; $display("FAIL after_done: pulses %0d count %0d done %b want 0 %0d 1", pulses, bus.rx_count, bus.rx_done, exp_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      read_mem(a, d);
      tests++;
      if (d !== exp_mem[a]) begin fails++; $display("FAIL after_done_mem[%0d]: got %h want %h", a, d, exp_mem[a]); end
    end
  endtask

  task automatic test_random_frames();
    logic v;
    logic [7:0] b, r, d;
    bit ok;
    int n, g;
    for (int f = 0; f < 6; f++) begin
      do_reset();
      n = int'($urandom_range(0, DEPTH));
      for (int k = 0; k < n; k++) begin
        r = 8'($urandom);
`ifdef RX_FRAME_CHK_EN
        g = -1;
`else
        g = int'($urandom_range(0, 7)) - 1;
`endif
        wait_ready(ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL rand_ready[%0d.%0d]: timeout", f, k); end
        send_byte(r, g, int'($urandom_range(1, 3)), v, b); model_accept(r);
        tests++;
        if (v !== 1'b1 || b !== r) begin fails++; $display("FAIL rand_byte[%0d.%0d]: vld %b byte %h want 1 %h", f, k, v, b, r); end
      end
      if (n < DEPTH) begin
        wait_ready(ok);
        send_finish(1'($urandom));
      end
      tests++;
      if (bus.rx_count !== 3'(exp_count) || bus.rx_done !== 1'b1 || bus.rx_err !== 1'b0) begin
        fails++; $display("FAIL rand_status[%0d]: count %0d done %b err %b want %0d 1 0", f, bus.rx_count, bus.rx_done, bus.rx_err, exp_count);
      end
      for (int a = 0; a < DEPTH; a++) begin
        read_mem(a, d);
        tests++;
        if (d !== exp_mem[a]) begin fails++; $display("FAIL rand_mem[%0d.%0d]: got %h want %h", f, a, d, exp_mem[a]); end
      end
    end
  endtask

  initial begin
    clr = 1'b0;
    bus.tx_data = 1'b0;
    bus.tx_vld = 1'b0;
    bus.tx_finish = 1'b0;
    bus.rd_addr = '0;
    model_clear();
    test_reset();
    test_full_frame();
    test_finish_early();
    test_gap();
    test_finish_with_vld();
    test_finish_in_recv();
    test_reset_mid_byte();
    test_after_done();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
